axis_byte_rotator: RTL and testbench
====================================

Name: axis_byte_rotator

Overview:
- AXI-Stream byte rotator. Each accepted beat is rotated by a per-beat runtime byte amount and direction, then buffered in a DEPTH-entry FIFO.
- Successor to the fixed-shift, two-entry stream shifter. Adds runtime shift and direction, configurable depth, tlast passthrough, full throughput and a fill-level status output.
- Sits between a packet source and a downstream AXI-Stream sink in the stream datapath.

Parameters:
- DATA_BUS_WIDTH, 4, bytes per beat (n); must be 2 or more.
- DEPTH, 4, FIFO entries; must be a power of 2 and 2 or more.
- SHIFT_W, $clog2(DATA_BUS_WIDTH), width of the shift amount (localparam).
- FULL_DATA_WIDTH, 8*DATA_BUS_WIDTH (localparam).

Ports:
- clk_i  in  1  single clock, rising edge.
- areset_i  in  1  asynchronous, active-high reset.
- tvalid_i  in  1  slave valid.
- tready_o  out  1  slave ready.
- tdata_i  in  FULL_DATA_WIDTH  slave data.
- tlast_i  in  1  slave end of packet.
- shift_i  in  SHIFT_W  rotate amount in bytes, sampled with the beat.
- dir_i  in  1  0 = rotate right, 1 = rotate left; sampled with the beat.
- tvalid_o  out  1  master valid.
- tready_i  in  1  master ready.
- tdata_o  out  FULL_DATA_WIDTH  master data, already rotated.
- tlast_o  out  1  master end of packet.
- level_o  out  $clog2(DEPTH)+1  current number of stored beats.

Behaviour:
- Interface: one clock (clk_i). Reset areset_i is asynchronous and active-high.
- Reset values:
  - tvalid_o=0, tdata_o=0, tlast_o=0, level_o=0.
  - Write and read pointers = 0.
  - tready_o=0 while areset_i is high. It rises the first cycle after deassertion.
- Handshakes:
  - Input transfer = tvalid_i && tready_o. Output transfer = tvalid_o && tready_i.
  - tready_o = (level != DEPTH), driven from registers only. There is no combinational path from tready_i.
  - tvalid_o = (level != 0).
  - tdata_o and tlast_o show the head entry and stay stable while tvalid_o=1 and tready_i=0.
- Rotation (applied on the write side and stored rotated), with k = 0..n-1 and s = shift_i:
  - Right: out byte k = in byte (k+s) mod n.
  - Left: out byte k = in byte (k-s) mod n.
  - Byte 0 = bits [7:0].
  - s=0 is identity.
  - s must be less than n. When n is not a power of 2, s >= n is reduced mod n.
- Latency: a beat accepted at edge t is visible on tdata_o with tvalid_o=1 after edge t (1 cycle), provided the FIFO was empty.
- Throughput: one beat per cycle sustained when tready_i=1.
- Level rules:
  - Simultaneous input and output transfer: level unchanged, both pointers advance.
  - Input only: level +1. Output only: level -1.
- Boundaries:
  - Full: level=DEPTH, so tready_o=0. A pop in that cycle still completes; tready_o returns 1 on the next cycle.
  - Empty: tvalid_o=0. An input at empty is not bypassed; 1-cycle latency always applies.
  - Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; level is tracked separately.
- Mid-operation reset: all stored beats are discarded immediately and outputs return to reset values asynchronously. No partial beat is emitted after release.
- tlast is carried unmodified with its beat. The block has no packet-level state.
- tdata_i, shift_i, dir_i and tlast_i are don't-care when tvalid_i=0.

Decomposition:
- Package axis_byte_rotator_pkg holds:
  - typedef rot_dir_e {ROT_RIGHT=0, ROT_LEFT=1};
  - a function rotate_bytes(data, shift, dir), parametrised through the calling module's widths via a localparam-sized argument;
  - the entry struct {data, last}.
- Sub-module byte_rotator: purely combinational, n-byte barrel rotate of log2(n) mux stages. It is instantiated once on the write path and tested standalone.
- FIFO storage and control stay in the top module.

Test Plan (DATA_BUS_WIDTH=4, DEPTH=4 unless noted):
- Single beat: tdata_i=0x44332211, shift_i=1, dir_i=0, tready_i=1 -> next cycle tvalid_o=1, tdata_o=0x11443322, then tvalid_o=0.
- Direction and sweep: 0x44332211 with dir_i=1, shift_i=1 -> 0x33221144. Right rotate with shift_i=0/2/3 -> 0x44332211 / 0x22114433 / 0x33221144.
- Fill and backpressure: tready_i=0, push 5 beats 0xA0..0xA4 -> tready_o falls after 4 beats, level_o=4, fifth beat held at source. Raise tready_i -> outputs in order 0xA0..0xA4 with shift 0, no loss or duplication.
- Full-rate streaming: tvalid_i=1, tready_i=1 for 100 beats of random data/shift/dir -> one output per cycle after 1-cycle latency, level_o stays 1, all outputs match the reference model, tlast_o aligned with its beat.
- Simultaneous push/pop at full: level=4 with tready_i=1 -> pop occurs, tready_o=1 next cycle, level_o=3 then stays steady under continuous push/pop.
- Reset mid-stream: with level_o=3, pulse areset_i for 1 cycle between edges -> tvalid_o=0 and level_o=0 immediately. After release tready_o=1, and a new beat 0x0D0C0B0A with shift 2 right -> 0x0B0A0D0C.

Source files
------------

// File: rtl/axis_byte_rotator_pkg.sv
// Shared types and a reference byte-rotate helper for the AXI-Stream byte rotator.
// Widths are capped at MAX_BUS_BYTES so one package serves every bus width.
package axis_byte_rotator_pkg;

  localparam int MAX_BUS_BYTES = 32;
  localparam int MAX_DATA_W    = 8 * MAX_BUS_BYTES;

  typedef enum logic {
    ROT_RIGHT = 1'b0,
    ROT_LEFT  = 1'b1
  } rot_dir_e;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  last;
  } entry_t;

  // Loop-based rotate of the low n bytes; amounts of n or more wrap mod n.
  function automatic logic [MAX_DATA_W-1:0] rotate_bytes(
    input logic [MAX_DATA_W-1:0] data,
    input int unsigned           shift,
    input rot_dir_e              dir,
    input int unsigned           n
  );
    logic [MAX_DATA_W-1:0] result;
    int unsigned           amt;
    int unsigned           src;
    result = '0;
    amt    = shift % n;
    for (int unsigned k = 0; k < n; k++) begin
      src = (dir == ROT_LEFT) ? (k + n - amt) % n : (k + amt) % n;
      result[8*k +: 8] = data[8*src +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_byte_rotator_byte_rotator.sv
// Combinational n-byte barrel rotator: one mux stage per shift bit.
// Stage i rotates by 2^i mod n, so any shift value wraps modulo n.
module byte_rotator
  import axis_byte_rotator_pkg::*;
#(
  parameter  int N       = 4,
  localparam int SHIFT_W = $clog2(N),
  localparam int W       = 8 * N
) (
  input  logic [W-1:0]       data,
  input  logic [SHIFT_W-1:0] shift,
  input  rot_dir_e           dir,
  output logic [W-1:0]       rotated
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < SHIFT_W; gi++) begin : g_stage
      localparam int AMT = (1 << gi) % N;
      logic [N-1:0][7:0] src;
      logic [N-1:0][7:0] q;

      if (gi == 0) begin : g_first
        assign src = data;
      end else begin : g_chain
        assign src = g_stage[gi-1].q;
      end

      for (gj = 0; gj < N; gj++) begin : g_byte
        localparam int RSRC = (gj + AMT) % N;
        localparam int LSRC = (gj + N - AMT) % N;
        assign q[gj] = !shift[gi]        ? src[gj]   :
                       (dir == ROT_LEFT) ? src[LSRC] : src[RSRC];
      end
    end
  endgenerate

  assign rotated = g_stage[SHIFT_W-1].q;

endmodule

// File: rtl/axis_byte_rotator.sv
// AXI-Stream byte rotator: rotates each accepted beat on the write side and
// buffers it in a DEPTH-entry FIFO with a registered ready and a fill level.
module axis_byte_rotator
  import axis_byte_rotator_pkg::*;
#(
  parameter  int DATA_BUS_WIDTH  = 4,
  parameter  int DEPTH           = 4,
  localparam int SHIFT_W         = $clog2(DATA_BUS_WIDTH),
  localparam int FULL_DATA_WIDTH = 8 * DATA_BUS_WIDTH,
  localparam int PTR_W           = $clog2(DEPTH),
  localparam int LEVEL_W         = $clog2(DEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       areset_i,
  input  logic                       tvalid_i,
  output logic                       tready_o,
  input  logic [FULL_DATA_WIDTH-1:0] tdata_i,
  input  logic                       tlast_i,
  input  logic [SHIFT_W-1:0]         shift_i,
  input  logic                       dir_i,
  output logic                       tvalid_o,
  input  logic                       tready_i,
  output logic [FULL_DATA_WIDTH-1:0] tdata_o,
  output logic                       tlast_o,
  output logic [LEVEL_W-1:0]         level_o
);

  logic [FULL_DATA_WIDTH-1:0] rotated;
  entry_t                     wr_entry;
  logic [FULL_DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                       mem_last [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_reg;
  logic [PTR_W-1:0]           rd_ptr_reg;
  logic [LEVEL_W-1:0]         level_reg;
  logic [LEVEL_W-1:0]         level_next;
  logic                       ready_reg;
  logic                       push;
  logic                       pop;

  byte_rotator #(.N(DATA_BUS_WIDTH)) u_rotator (
    .data    (tdata_i),
    .shift   (shift_i),
    .dir     (rot_dir_e'(dir_i)),
    .rotated (rotated)
  );

  always_comb begin
    wr_entry                           = '0;
    wr_entry.data[FULL_DATA_WIDTH-1:0] = rotated;
    wr_entry.last                      = tlast_i;
  end

  generate
    if (FULL_DATA_WIDTH < MAX_DATA_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^wr_entry.data[MAX_DATA_W-1:FULL_DATA_WIDTH];
    end
  endgenerate

  assign push = tvalid_i && ready_reg;
  assign pop  = tvalid_o && tready_i;

  always_comb begin
    level_next = level_reg;
    unique case ({push, pop})
      2'b10:   level_next = level_reg + LEVEL_W'(1);
      2'b01:   level_next = level_reg - LEVEL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // Ready is registered from the next level so it never depends on tready_i.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
      ready_reg <= (level_next != LEVEL_W'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= wr_entry.data[FULL_DATA_WIDTH-1:0];
      mem_last[wr_ptr_reg] <= wr_entry.last;
    end
  end

  // Storage is not cleared by reset, so the head is masked while empty.
  assign tvalid_o = (level_reg != '0);
  assign tready_o = ready_reg;
  assign tdata_o  = tvalid_o ? mem_data[rd_ptr_reg] : '0;
  assign tlast_o  = tvalid_o ? mem_last[rd_ptr_reg] : 1'b0;
  assign level_o  = level_reg;

endmodule

// File: tb/tb_axis_byte_rotator.sv
// Directed bench for axis_byte_rotator (n=4, DEPTH=4) plus a standalone
// check of a 3-byte byte_rotator for modulo wrap of the shift amount.
module tb_axis_byte_rotator;
  import axis_byte_rotator_pkg::*;

  logic        clk = 1'b0;
  logic        areset_i;
  logic        tvalid_i;
  logic        tready_o;
  logic [31:0] tdata_i;
  logic        tlast_i;
  logic [1:0]  shift_i;
  logic        dir_i;
  logic        tvalid_o;
  logic        tready_i;
  logic [31:0] tdata_o;
  logic        tlast_o;
  logic [2:0]  level_o;

  logic [23:0] r3_data;
  logic [1:0]  r3_shift;
  rot_dir_e    r3_dir;
  logic [23:0] r3_out;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  axis_byte_rotator #(.DATA_BUS_WIDTH(4), .DEPTH(4)) dut (
    .clk_i    (clk),
    .areset_i (areset_i),
    .tvalid_i (tvalid_i),
    .tready_o (tready_o),
    .tdata_i  (tdata_i),
    .tlast_i  (tlast_i),
    .shift_i  (shift_i),
    .dir_i    (dir_i),
    .tvalid_o (tvalid_o),
    .tready_i (tready_i),
    .tdata_o  (tdata_o),
    .tlast_o  (tlast_o),
    .level_o  (level_o)
  );

  byte_rotator #(.N(3)) u_rot3 (
    .data    (r3_data),
    .shift   (r3_shift),
    .dir     (r3_dir),
    .rotated (r3_out)
  );

  function automatic logic [31:0] rot_model(logic [31:0] d, int s, bit left);
    logic [31:0] r;
    int src;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      src = left ? (k - s + 4) % 4 : (k + s) % 4;
      r[8*k +: 8] = d[8*src +: 8];
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score any output handshake, record any input handshake.
  task automatic tick();
    bit in_fire;
    bit out_fire;
    logic [32:0] e;
    in_fire  = tvalid_i && tready_o;
    out_fire = tvalid_o && tready_i;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", {31'd0, tvalid_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", tdata_o, e[32:1]);
        chk("sb_last", {31'd0, tlast_o}, {31'd0, e[0]});
      end
    end
    if (in_fire) exp_q.push_back({rot_model(tdata_i, int'(shift_i), dir_i), tlast_i});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] d, logic [1:0] s, logic dr, logic l);
    tvalid_i = 1'b1;
    tdata_i  = d;
    shift_i  = s;
    dir_i    = dr;
    tlast_i  = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_i = 1'b1;
    tvalid_i = 1'b0;
    tdata_i  = '0;
    tlast_i  = 1'b0;
    shift_i  = '0;
    dir_i    = 1'b0;
    tready_i = 1'b1;

    // standalone 3-byte rotator: amounts wrap modulo 3
    r3_data = 24'h332211; r3_shift = 2'd1; r3_dir = ROT_RIGHT; #1;
    chk("rot3_r1", {8'd0, r3_out}, 32'h00113322);
    r3_shift = 2'd2; r3_dir = ROT_LEFT; #1;
    chk("rot3_l2", {8'd0, r3_out}, 32'h00113322);
    r3_shift = 2'd3; r3_dir = ROT_RIGHT; #1;
    chk("rot3_r3", {8'd0, r3_out}, 32'h00332211);

    #9;
    chk("rst_tready", {31'd0, tready_o}, 32'd0);
    chk("rst_tvalid", {31'd0, tvalid_o}, 32'd0);
    chk("rst_tdata",  tdata_o, 32'd0);
    chk("rst_tlast",  {31'd0, tlast_o}, 32'd0);
    chk("rst_level",  {29'd0, level_o}, 32'd0);
    areset_i = 1'b0;
    @(posedge clk); #1;
    chk("rel_tready", {31'd0, tready_o}, 32'd1);

    // single beat, right by 1
    drive(32'h44332211, 2'd1, 1'b0, 1'b1);
    tick();
    tvalid_i = 1'b0;
    chk("single_valid", {31'd0, tvalid_o}, 32'd1);
    chk("single_data",  tdata_o, 32'h11443322);
    chk("single_last",  {31'd0, tlast_o}, 32'd1);
    chk("single_level", {29'd0, level_o}, 32'd1);
    tick();
    chk("single_empty", {31'd0, tvalid_o}, 32'd0);

    // direction and shift sweep, back to back
    drive(32'h44332211, 2'd1, 1'b1, 1'b0); tick();
    chk("left1",  tdata_o, 32'h33221144);
    drive(32'h44332211, 2'd0, 1'b0, 1'b0); tick();
    chk("right0", tdata_o, 32'h44332211);
    drive(32'h44332211, 2'd2, 1'b0, 1'b0); tick();
    chk("right2", tdata_o, 32'h22114433);
    drive(32'h44332211, 2'd3, 1'b0, 1'b1); tick();
    chk("right3", tdata_o, 32'h33221144);
    chk("right3_last", {31'd0, tlast_o}, 32'd1);
    tvalid_i = 1'b0;
    tick();
    chk("sweep_empty", {31'd0, tvalid_o}, 32'd0);

    // fill under backpressure
    tready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'hA0 + i, 2'd0, 1'b0, 1'b0);
      tick();
    end
    chk("full_level",  {29'd0, level_o}, 32'd4);
    chk("full_tready", {31'd0, tready_o}, 32'd0);
    chk("full_head",   tdata_o, 32'h000000A0);
    drive(32'hA4, 2'd0, 1'b0, 1'b1);
    tick();
    chk("held_level", {29'd0, level_o}, 32'd4);
    tready_i = 1'b1;
    tick();
    chk("pop_full_level",  {29'd0, level_o}, 32'd3);
    chk("pop_full_tready", {31'd0, tready_o}, 32'd1);
    chk("pop_full_head",   tdata_o, 32'h000000A1);
    tick();
    chk("pushpop_level_a", {29'd0, level_o}, 32'd3);
    drive(32'hB0, 2'd0, 1'b0, 1'b0); tick();
    chk("pushpop_level_b", {29'd0, level_o}, 32'd3);
    drive(32'hB1, 2'd0, 1'b0, 1'b1); tick();
    chk("pushpop_level_c", {29'd0, level_o}, 32'd3);
    tvalid_i = 1'b0;
    for (int i = 0; i < 10 && tvalid_o; i++) tick();
    chk("drain_valid", {31'd0, tvalid_o}, 32'd0);
    chk("drain_level", {29'd0, level_o}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);

    // full-rate random stream
    for (int i = 0; i < 100; i++) begin
      drive($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      tick();
      chk("stream_level", {29'd0, level_o}, 32'd1);
      chk("stream_valid", {31'd0, tvalid_o}, 32'd1);
    end
    tvalid_i = 1'b0;
    tick();
    chk("stream_end_valid", {31'd0, tvalid_o}, 32'd0);
    chk("stream_end_queue", exp_q.size(), 32'd0);

    // reset in the middle of a stream
    tready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hC0 + i, 2'd0, 1'b0, 1'b0);
      tick();
    end
    tvalid_i = 1'b0;
    chk("pre_rst_level", {29'd0, level_o}, 32'd3);
    #3;
    areset_i = 1'b1;
    #1;
    chk("mid_rst_valid",  {31'd0, tvalid_o}, 32'd0);
    chk("mid_rst_level",  {29'd0, level_o}, 32'd0);
    chk("mid_rst_tdata",  tdata_o, 32'd0);
    chk("mid_rst_tready", {31'd0, tready_o}, 32'd0);
    #2;
    areset_i = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("post_rst_tready", {31'd0, tready_o}, 32'd1);
    chk("post_rst_valid",  {31'd0, tvalid_o}, 32'd0);
    tready_i = 1'b1;
    drive(32'h0D0C0B0A, 2'd2, 1'b0, 1'b0);
    tick();
    tvalid_i = 1'b0;
    chk("post_rst_data",  tdata_o, 32'h0B0A0D0C);
    chk("post_rst_level", {29'd0, level_o}, 32'd1);
    tick();
    chk("post_rst_empty", {31'd0, tvalid_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
